// File: rtl/scan_display_pkg.sv
// Shared types and width helpers for the multiplexed display scanner.
package scan_display_pkg;

  // Scanner phases: CLEAR only after reset, then SHIFT/LATCH/DWELL per digit.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DWELL = 2'd3
  } state_e;

  // Serial word length: one-hot digit select followed by the segment bits.
  function automatic int word_bits(input int num_digits, input int seg_bits);
    return num_digits + seg_bits;
  endfunction

  // Counter width able to index 0..count-1; never narrower than one bit.
  function automatic int cnt_bits(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/scan_display_if.sv
// Frame upload handshake between panel status logic and the scanner.
interface scan_display_if #(
  parameter int FRAME_BITS = 192
) ();

  logic [FRAME_BITS-1:0] frame_in;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/scan_display_shifter.sv
// Serialiser for one W-bit word into the external shift-register chain.
// Each bit spends CLK_DIV cycles with sclk low (data changes on entry)
// and CLK_DIV cycles with sclk high. done flags the final cycle of the
// last high phase so the controller can move on without a gap cycle.
module display_shifter
  import scan_display_pkg::*;
#(
  parameter int W       = 32,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] word,
  output logic         sclk,
  output logic         sdata,
  output logic         done
);

  localparam int DIV_W = cnt_bits(CLK_DIV);
  localparam int BIT_W = cnt_bits(W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

  logic [W-1:0]     shreg_r;
  logic [DIV_W-1:0] div_r;
  logic [BIT_W-1:0] bit_r;
  logic             busy_r;
  logic             sclk_r;
  logic             sdata_r;
  logic             phase_end_s;

  assign phase_end_s = busy_r && (div_r == DIV_LAST);
  assign done        = phase_end_s && sclk_r && (bit_r == BIT_LAST);
  assign sclk        = sclk_r;
  assign sdata       = sdata_r;

  // Walk the loaded word MSB first, toggling sclk every CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= {W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      busy_r  <= 1'b0;
      sclk_r  <= 1'b0;
      sdata_r <= 1'b0;
    end else if (load) begin
      shreg_r <= word;
      sdata_r <= word[W-1];
      sclk_r  <= 1'b0;
      div_r   <= {DIV_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      if (div_r == DIV_LAST) begin
        div_r <= {DIV_W{1'b0}};
        if (!sclk_r) begin
          sclk_r <= 1'b1;
        end else if (bit_r == BIT_LAST) begin
          busy_r  <= 1'b0;
          sclk_r  <= 1'b0;
          sdata_r <= 1'b0;
        end else begin
          bit_r   <= bit_r + 1'b1;
          shreg_r <= shreg_r << 1;
          sdata_r <= shreg_r[W-2];
          sclk_r  <= 1'b0;
        end
      end else begin
        div_r <= div_r + 1'b1;
      end
    end else begin
      sclk_r <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_display.sv
// Multiplexed front-panel display scanner. A frame is uploaded into a
// shadow buffer and only copied into the active buffer when the scan wraps
// from the last digit back to digit 0, so a frame is never shown torn.
// Each digit is shifted out, latched, then held for a PWM-dimmed dwell.
module scan_display
  import scan_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SEG_BITS    = 24,
  parameter int CLK_DIV     = 4,
  parameter int DWELL_LOG2  = 12,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scan_display_if.slave          frame_bus,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic                   sclk,
  output logic                   sdata,
  output logic                   sload,
  output logic                   sclr_n,
  output logic                   oe_n,
  output logic                   scan_done
);

  localparam int W          = word_bits(NUM_DIGITS, SEG_BITS);
  localparam int FRAME_BITS = NUM_DIGITS * SEG_BITS;
  localparam int DIG_W      = cnt_bits(NUM_DIGITS);
  localparam int HOLD_W     = cnt_bits(2 * CLK_DIV);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(2 * CLK_DIV - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [DWELL_LOG2-1:0] DWELL_LAST = {DWELL_LOG2{1'b1}};

  state_e                  state_r;
  logic [HOLD_W-1:0]       hold_r;
  logic [DWELL_LOG2-1:0]   dwell_r;
  logic [DIG_W-1:0]        digit_r;
  logic [BRIGHT_BITS-1:0]  bright_r;
  logic [FRAME_BITS-1:0]   active_r;
  logic [FRAME_BITS-1:0]   shadow_r;
  logic                    ready_r;
  logic                    sload_r;
  logic                    sclr_n_r;
  logic                    oe_n_r;
  logic                    scan_done_r;

  logic                    clear_end_s;
  logic                    dwell_end_s;
  logic                    wrap_s;
  logic                    swap_s;
  logic                    load_s;
  logic                    shift_done_s;
  logic [DIG_W-1:0]        next_digit_s;
  logic [FRAME_BITS-1:0]   frame_s;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [SEG_BITS-1:0]     seg_s;
  logic [W-1:0]            word_s;
  logic [BRIGHT_BITS-1:0]  dwell_top_next_s;

  assign sload                = sload_r;
  assign sclr_n               = sclr_n_r;
  assign oe_n                 = oe_n_r;
  assign scan_done            = scan_done_r;
  assign frame_bus.frame_ready = ready_r;

  // Decode phase ends and build the next digit word; on the wrap cycle the
  // word is taken from the shadow so the new frame starts at digit 0.
  always_comb begin
    clear_end_s      = (state_r == ST_CLEAR) && (hold_r == HOLD_LAST);
    dwell_end_s      = (state_r == ST_DWELL) && (dwell_r == DWELL_LAST);
    wrap_s           = dwell_end_s && (digit_r == DIG_LAST);
    swap_s           = wrap_s && !ready_r;
    load_s           = clear_end_s || dwell_end_s;
    dwell_top_next_s = BRIGHT_BITS'((dwell_r + 1'b1) >> (DWELL_LOG2 - BRIGHT_BITS));
    if (clear_end_s || wrap_s) begin
      next_digit_s = {DIG_W{1'b0}};
    end else begin
      next_digit_s = digit_r + 1'b1;
    end
    if (swap_s) begin
      frame_s = shadow_r;
    end else begin
      frame_s = active_r;
    end
    sel_s  = NUM_DIGITS'(1'b1) << next_digit_s;
    seg_s  = frame_s[next_digit_s * SEG_BITS +: SEG_BITS];
    word_s = {sel_s, seg_s};
  end

  display_shifter #(
    .W       (W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .word  (word_s),
    .sclk  (sclk),
    .sdata (sdata),
    .done  (shift_done_s)
  );

  // Scan sequencer: steps through the per-digit phases and drives the
  // registered latch, clear, output-enable and scan-complete strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_CLEAR;
      hold_r      <= {HOLD_W{1'b0}};
      dwell_r     <= {DWELL_LOG2{1'b0}};
      digit_r     <= {DIG_W{1'b0}};
      bright_r    <= {BRIGHT_BITS{1'b0}};
      sload_r     <= 1'b0;
      sclr_n_r    <= 1'b0;
      oe_n_r      <= 1'b1;
      scan_done_r <= 1'b0;
    end else begin
      scan_done_r <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          if (clear_end_s) begin
            state_r  <= ST_SHIFT;
            hold_r   <= {HOLD_W{1'b0}};
            sclr_n_r <= 1'b1;
            digit_r  <= next_digit_s;
          end else begin
            hold_r <= hold_r + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift_done_s) begin
            state_r <= ST_LATCH;
            hold_r  <= {HOLD_W{1'b0}};
            sload_r <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_LATCH: begin
          if (hold_r == HOLD_LAST) begin
            state_r  <= ST_DWELL;
            hold_r   <= {HOLD_W{1'b0}};
            dwell_r  <= {DWELL_LOG2{1'b0}};
            sload_r  <= 1'b0;
            bright_r <= brightness;
            // First dwell cycle has counter top bits 0: lit unless blanked.
            oe_n_r   <= (brightness == {BRIGHT_BITS{1'b0}});
          end else begin
            hold_r <= hold_r + 1'b1;
          end
        end
        ST_DWELL: begin
          if (dwell_end_s) begin
            state_r     <= ST_SHIFT;
            digit_r     <= next_digit_s;
            oe_n_r      <= 1'b1;
            scan_done_r <= wrap_s;
          end else begin
            dwell_r <= dwell_r + 1'b1;
            oe_n_r  <= !(dwell_top_next_s < bright_r);
          end
        end
        default: begin
          state_r  <= ST_CLEAR;
          hold_r   <= {HOLD_W{1'b0}};
          sload_r  <= 1'b0;
          sclr_n_r <= 1'b0;
          oe_n_r   <= 1'b1;
        end
      endcase
    end
  end

  // Frame buffers: accept into the shadow when empty, promote on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= {FRAME_BITS{1'b0}};
      shadow_r <= {FRAME_BITS{1'b0}};
      ready_r  <= 1'b1;
    end else if (swap_s) begin
      active_r <= shadow_r;
      ready_r  <= 1'b1;
    end else if (frame_bus.frame_valid && ready_r) begin
      shadow_r <= frame_bus.frame_in;
      ready_r  <= 1'b0;
    end else begin
      ready_r <= ready_r;
    end
  end

endmodule

// File: tb/tb_scan_display.sv
// Directed bench for scan_display with a 2-digit, 4-segment panel:
// W=6, 30 cycles per digit, 60 cycles per frame.
module tb_scan_display;

  localparam int ND = 2;
  localparam int SB = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] brightness;
  logic       sclk, sdata, sload, sclr_n, oe_n, scan_done;

  int checks = 0;
  int errors = 0;

  scan_display_if #(.FRAME_BITS(ND * SB)) bus ();

  scan_display #(
    .NUM_DIGITS  (ND),
    .SEG_BITS    (SB),
    .CLK_DIV     (1),
    .DWELL_LOG2  (4),
    .BRIGHT_BITS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_bus  (bus),
    .brightness (brightness),
    .sclk       (sclk),
    .sdata      (sdata),
    .sload      (sload),
    .sclr_n     (sclr_n),
    .oe_n       (oe_n),
    .scan_done  (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {sclk, sdata, sload, sclr_n, oe_n, scan_done, frame_ready}
  function automatic logic [6:0] outs();
    return {sclk, sdata, sload, sclr_n, oe_n, scan_done, bus.frame_ready};
  endfunction

  // Count cycles with sclr_n low starting at the release point.
  task automatic check_clear(input string tag);
    int n = 0;
    while (sclr_n === 1'b0 && n < 10) begin
      n++;
      step();
    end
    check(tag, 32'(n), 32'd2);
  endtask

  // Observe one 30-cycle digit period starting at its first SHIFT cycle.
  task automatic window(input string tag, input logic [5:0] exp_w, input int exp_oe,
                        input int exp_done, input int chg_at, input logic [1:0] chg_val);
    logic [5:0] w = 6'd0;
    logic prev = 1'b0;
    int rises = 0, loads = 0, oe_low = 0, dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == chg_at) brightness = chg_val;
      if (sclk === 1'b1 && prev === 1'b0) begin
        w = {w[4:0], sdata};
        rises++;
      end
      prev = sclk;
      if (sload === 1'b1) loads++;
      if (oe_n === 1'b0) oe_low++;
      if (scan_done === 1'b1) dones++;
      step();
    end
    check({tag, "_word"},  32'(w),      32'(exp_w));
    check({tag, "_sclk"},  32'(rises),  32'd6);
    check({tag, "_sload"}, 32'(loads),  32'd2);
    check({tag, "_oe"},    32'(oe_low), 32'(exp_oe));
    check({tag, "_done"},  32'(dones),  32'(exp_done));
  endtask

  initial begin
    rst_n           = 1'b0;
    brightness      = 2'd0;
    bus.frame_in    = 8'h00;
    bus.frame_valid = 1'b0;
    step();
    step();
    check("reset_outs", 32'(outs()), 32'(7'b0000101));

    // Release and verify the power-up clear, then the empty first frame.
    rst_n = 1'b1;
    check_clear("clear_len");
    bus.frame_in    = 8'hA5;
    bus.frame_valid = 1'b1;
    window("a_d0", 6'b01_0000, 0, 0, -1, 2'd0);
    check("ready_full", 32'(bus.frame_ready), 32'd0);

    // Second frame offered while the shadow is full: must wait.
    bus.frame_in = 8'h3C;
    brightness   = 2'd2;
    window("b_d1", 6'b10_0000, 8, 0, -1, 2'd0);
    check("ready_after_swap", 32'(bus.frame_ready), 32'd1);
    check("scan_done_wrap", 32'(scan_done), 32'd1);

    // A5 now active; 3C captured on the cycle after the swap.
    brightness = 2'd3;
    window("c_d0", 6'b01_0101, 12, 1, -1, 2'd0);
    bus.frame_valid = 1'b0;
    check("ready_3c_taken", 32'(bus.frame_ready), 32'd0);

    // Brightness dropped mid-dwell: this dwell still uses 3.
    window("d_d1", 6'b10_1010, 12, 0, 20, 2'd0);
    window("e_d0", 6'b01_1100, 0, 1, -1, 2'd0);
    brightness = 2'd1;
    window("f_d1", 6'b10_0011, 4, 0, -1, 2'd0);

    // Load a frame into the shadow, then reset in the middle of SHIFT.
    bus.frame_in    = 8'hFF;
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    step();
    step();
    check("ready_ff_taken", 32'(bus.frame_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midshift_reset_outs", 32'(outs()), 32'(7'b0000101));
    step();
    step();
    rst_n = 1'b1;
    check_clear("clear_len_again");
    window("g_d0", 6'b01_0000, 4, 0, -1, 2'd0);
    window("h_d1", 6'b10_0000, 4, 0, -1, 2'd0);
    window("i_d0", 6'b01_0000, 4, 1, -1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
